rate_monitor: RTL and testbench
===============================

RATE_MONITOR -- requirements
Module: rate_monitor

Interface
REQ-001 Parameter AVG_LOG2, default 3: averaging depth of 2^AVG_LOG2 windows, legal range 1..6.
REQ-002 Parameter LOW_THR, default 18'd9600: degrade threshold.
REQ-003 Parameter HIGH_THR, default 18'd19200: recover threshold; must satisfy HIGH_THR > LOW_THR.
REQ-004 Parameter LOST_CNT, default 3: number of consecutive zero windows that declares loss.
REQ-005 Parameter WDOG_MAX, default 17'd61439: watchdog limit in clk cycles (two 1 ms windows at 30.72 MHz).
REQ-006 clk  in  1  30.72 MHz clock, sole clock domain.
REQ-007 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-008 d_in  in  18  per-window count from the upstream 1 ms speed meter.
REQ-009 d_valid  in  1  one-cycle strobe; d_in is valid when high.
REQ-010 clr  in  1  synchronous statistics clear, one-cycle pulse.
REQ-011 avg_out  out  18  moving average of the last 2^AVG_LOG2 samples.
REQ-012 avg_valid  out  1  one-cycle strobe qualifying avg_out.
REQ-013 min_out / max_out  out  18 each  minimum and maximum sample since reset or clr.
REQ-014 link_state  out  2  encoding: 0=INIT, 1=OK, 2=DEGRADED, 3=LOST.
REQ-015 alarm  out  1  high while link_state==LOST.
REQ-016 wdog_err  out  1  sticky watchdog flag.

Function
REQ-017 Sample storage: circular buffer of 2^AVG_LOG2 x 18 bits, write pointer wptr, fill counter fill (0..2^AVG_LOG2).
REQ-018 On d_valid: buf[wptr]<=d_in; wptr increments modulo 2^AVG_LOG2; sum (18+AVG_LOG2 bits, no overflow) <= sum + d_in - (full ? buf[wptr] : 0).
REQ-019 avg_out <= new sum >> AVG_LOG2 (truncating); avg_valid pulses one cycle after d_valid, and only when the buffer is full after that sample.
REQ-020 min/max: on d_valid, min_out <= min(min_out, d_in) and max_out <= max(max_out, d_in); values update one cycle after d_valid.
REQ-021 clr: sum, fill and wptr go to 0; min_out goes to 18'h3FFFF; max_out goes to 0; buffer contents are not erased because fill==0 masks them.
REQ-022 clr coincident with d_valid: the clear takes effect, then the sample is applied as the first sample (fill=1, min_out=max_out=d_in).
REQ-023 FSM transitions are evaluated on each avg_valid using the new avg_out.
  - INIT -> OK when avg >= HIGH_THR; otherwise INIT -> DEGRADED.
  - OK -> DEGRADED when avg < LOW_THR.
  - DEGRADED -> OK when avg >= HIGH_THR.
REQ-024 zero_cnt increments on each d_valid with d_in==0 (saturating at LOST_CNT) and is cleared by any d_valid with nonzero d_in; this is independent of the fill state.
REQ-025 Any state -> LOST when zero_cnt reaches LOST_CNT; this takes priority over REQ-023 in the same cycle.
REQ-026 LOST -> DEGRADED on the first d_valid with d_in != 0; avg-based transitions out of LOST are ignored.
REQ-027 clr returns the FSM to INIT and clears zero_cnt.

Reset
REQ-028 While reset_n is low, the following are held:
  - avg_out=0, avg_valid=0, min_out=18'h3FFFF, max_out=0;
  - link_state=INIT, alarm=0, wdog_err=0;
  - sum=0, fill=0, wptr=0, zero_cnt=0, watchdog counter=0.
REQ-029 Reset asserted mid-operation aborts all state immediately; the first d_valid after release is treated as sample 1.

Configuration
REQ-030 Macro RATE_MON_WDOG_EN defined: a 17-bit counter clears on each d_valid and otherwise increments, saturating.
  - When the counter reaches WDOG_MAX, the FSM forces LOST and wdog_err sets.
  - wdog_err clears only on clr or reset.
  - If d_valid occurs in the same cycle the counter reaches WDOG_MAX, d_valid wins and no trip occurs.
REQ-031 Macro RATE_MON_WDOG_EN undefined: no counter is instantiated and wdog_err is tied to 0.

Verification
REQ-032 AVG_LOG2=3; 8 strobes of d_in=19200 -> avg_valid only on the 8th (one cycle later), avg_out=19200, link_state INIT->OK.
REQ-033 From OK, strobes of 0 -> state DEGRADED once avg < 9600, then LOST with alarm=1 after the 3rd consecutive zero; next strobe d_in=1920 -> DEGRADED, alarm=0.
REQ-034 Samples 3840, 1920, 57600 then clr coincident with d_valid d_in=5760 -> min_out=max_out=5760, fill=1, state INIT.
REQ-035 Buffer wrap: 8 x 1920 then 8 x 3840 -> avg_out rises by 240 per strobe and ends at 3840; sum never overflows.
REQ-036 RATE_MON_WDOG_EN defined, no d_valid for 61440 cycles -> wdog_err=1, link_state=LOST; d_valid at cycle 61439 -> no trip.
REQ-037 Assert reset_n low mid-fill after 5 samples, then release -> all outputs at reset values; 8 further strobes are needed before the first avg_valid.

Source files
------------

// File: rtl/rate_monitor.sv
// Rate monitor: moving average, min/max and link-health FSM over per-window rate samples.
// Optional stall watchdog is built in when RATE_MON_WDOG_EN is defined.
module rate_monitor #(
   parameter int unsigned AVG_LOG2 = 3,
   parameter logic [17:0] LOW_THR  = 18'd9600,
   parameter logic [17:0] HIGH_THR = 18'd19200,
   parameter int unsigned LOST_CNT = 3,
   parameter logic [16:0] WDOG_MAX = 17'd61439
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [17:0] d_in,
   input  logic        d_valid,
   input  logic        clr,
   output logic [17:0] avg_out,
   output logic        avg_valid,
   output logic [17:0] min_out,
   output logic [17:0] max_out,
   output logic [1:0]  link_state,
   output logic        alarm,
   output logic        wdog_err
);

   localparam int unsigned SumW = 18 + AVG_LOG2;
   localparam int unsigned ZcW  = $clog2(LOST_CNT + 1);
   localparam logic [ZcW-1:0] ZcMax = ZcW'(LOST_CNT);

   typedef enum logic [1:0] {
      StInit     = 2'd0,
      StOk       = 2'd1,
      StDegraded = 2'd2,
      StLost     = 2'd3
   } state_e;

   logic [17:0]         samp_q [2**AVG_LOG2];
   logic [SumW-1:0]     sum_q, sum_d, sum_base;
   logic [AVG_LOG2:0]   fill_q, fill_d, fill_base;
   logic [AVG_LOG2-1:0] wptr_q, wptr_d, wptr_base;
   logic [ZcW-1:0]      zc_q, zc_d, zc_base;
   logic [17:0]         min_q, min_d, min_base;
   logic [17:0]         max_q, max_d, max_base;
   logic [17:0]         avg_q, avg_d, old_samp;
   logic                avg_valid_q, avg_valid_d;
   logic                alarm_q, alarm_d;
   state_e              state_q, state_d, state_base;
   logic                wdog_trip;

   always_comb begin
      // A clear coincident with a strobe behaves as clear-then-sample.
      sum_base   = clr ? '0 : sum_q;
      fill_base  = clr ? '0 : fill_q;
      wptr_base  = clr ? '0 : wptr_q;
      zc_base    = clr ? '0 : zc_q;
      min_base   = clr ? 18'h3FFFF : min_q;
      max_base   = clr ? 18'h0 : max_q;
      state_base = clr ? StInit : state_q;
      old_samp   = fill_base[AVG_LOG2] ? samp_q[wptr_base] : 18'h0;

      sum_d       = sum_base;
      fill_d      = fill_base;
      wptr_d      = wptr_base;
      zc_d        = zc_base;
      min_d       = min_base;
      max_d       = max_base;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      state_d     = state_base;

      if (d_valid) begin
         sum_d       = sum_base + SumW'(d_in) - SumW'(old_samp);
         wptr_d      = wptr_base + 1'b1;
         fill_d      = fill_base[AVG_LOG2] ? fill_base : fill_base + 1'b1;
         min_d       = (d_in < min_base) ? d_in : min_base;
         max_d       = (d_in > max_base) ? d_in : max_base;
         avg_d       = sum_d[SumW-1:AVG_LOG2];
         avg_valid_d = fill_d[AVG_LOG2];
         if (d_in == 18'h0) begin
            zc_d = (zc_base == ZcMax) ? zc_base : zc_base + 1'b1;
         end else begin
            zc_d = '0;
         end

         if (zc_d == ZcMax) begin
            state_d = StLost;
         end else if (state_base == StLost) begin
            state_d = StDegraded;
         end else if (avg_valid_d) begin
            unique case (state_base)
               StInit:     state_d = (avg_d >= HIGH_THR) ? StOk : StDegraded;
               StOk:       state_d = (avg_d < LOW_THR) ? StDegraded : StOk;
               StDegraded: state_d = (avg_d >= HIGH_THR) ? StOk : StDegraded;
               default:    state_d = state_base;
            endcase
         end
      end

      if (wdog_trip) begin
         state_d = StLost;
      end
      alarm_d = (state_d == StLost);
   end

   // Buffer contents need no reset: fill masks stale entries.
   always_ff @(posedge clk) begin
      if (d_valid) begin
         samp_q[wptr_base] <= d_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q       <= '0;
         fill_q      <= '0;
         wptr_q      <= '0;
         zc_q        <= '0;
         min_q       <= 18'h3FFFF;
         max_q       <= 18'h0;
         avg_q       <= 18'h0;
         avg_valid_q <= 1'b0;
         state_q     <= StInit;
         alarm_q     <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         fill_q      <= fill_d;
         wptr_q      <= wptr_d;
         zc_q        <= zc_d;
         min_q       <= min_d;
         max_q       <= max_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         state_q     <= state_d;
         alarm_q     <= alarm_d;
      end
   end

`ifdef RATE_MON_WDOG_EN
   logic [16:0] wdog_q, wdog_d;
   logic        wdog_err_q, wdog_err_d;

   // A strobe arriving in the same cycle the limit is reached suppresses the trip.
   assign wdog_trip = !clr && !d_valid && (wdog_q == WDOG_MAX);

   always_comb begin
      if (clr || d_valid) begin
         wdog_d = '0;
      end else if (wdog_q == WDOG_MAX) begin
         wdog_d = wdog_q;
      end else begin
         wdog_d = wdog_q + 1'b1;
      end
      wdog_err_d = clr ? 1'b0 : (wdog_err_q | wdog_trip);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdog_q     <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_q     <= wdog_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign wdog_err = wdog_err_q;
`else
   assign wdog_trip = 1'b0;
   assign wdog_err  = 1'b0;
`endif

   assign avg_out    = avg_q;
   assign avg_valid  = avg_valid_q;
   assign min_out    = min_q;
   assign max_out    = max_q;
   assign link_state = state_q;
   assign alarm      = alarm_q;

endmodule

// File: tb/tb_rate_monitor.sv
// Directed self-checking bench for rate_monitor (averaging, min/max, link FSM, clear, reset,
// and the watchdog when RATE_MON_WDOG_EN is defined).
module tb_rate_monitor;

   // Shortened watchdog limit keeps the run short; trip/no-trip boundary behaviour is the same.
   localparam logic [16:0] TbWdogMax = 17'd4095;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [17:0] d_in;
   logic        d_valid;
   logic        clr;
   logic [17:0] avg_out;
   logic        avg_valid;
   logic [17:0] min_out;
   logic [17:0] max_out;
   logic [1:0]  link_state;
   logic        alarm;
   logic        wdog_err;

   int tests = 0;
   int fails = 0;

   rate_monitor #(
      .AVG_LOG2 (3),
      .LOW_THR  (18'd9600),
      .HIGH_THR (18'd19200),
      .LOST_CNT (3),
      .WDOG_MAX (TbWdogMax)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .d_in       (d_in),
      .d_valid    (d_valid),
      .clr        (clr),
      .avg_out    (avg_out),
      .avg_valid  (avg_valid),
      .min_out    (min_out),
      .max_out    (max_out),
      .link_state (link_state),
      .alarm      (alarm),
      .wdog_err   (wdog_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [17:0] v, input logic with_clr);
      @(negedge clk);
      d_in    = v;
      d_valid = 1'b1;
      clr     = with_clr;
      @(negedge clk);
      d_valid = 1'b0;
      clr     = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_avg"}, 32'(avg_out), 32'd0);
      check({tag, "_avgv"}, 32'(avg_valid), 32'd0);
      check({tag, "_min"}, 32'(min_out), 32'h3FFFF);
      check({tag, "_max"}, 32'(max_out), 32'd0);
      check({tag, "_state"}, 32'(link_state), 32'd0);
      check({tag, "_alarm"}, 32'(alarm), 32'd0);
      check({tag, "_wdog"}, 32'(wdog_err), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      d_in    = '0;
      d_valid = 1'b0;
      clr     = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset_n = 1'b1;

      // Fill with 19200: first average only on the 8th strobe, INIT -> OK at exactly HIGH_THR.
      for (int i = 0; i < 7; i++) begin
         strobe(18'd19200, 1'b0);
         check($sformatf("fill_avgv_%0d", i), 32'(avg_valid), 32'd0);
      end
      strobe(18'd19200, 1'b0);
      check("fill8_avgv", 32'(avg_valid), 32'd1);
      check("fill8_avg", 32'(avg_out), 32'd19200);
      check("fill8_state", 32'(link_state), 32'd1);
      @(negedge clk);
      check("avgv_one_cycle", 32'(avg_valid), 32'd0);
      check("fill_minmax", {min_out[15:0], max_out[15:0]}, {16'd19200, 16'd19200});

      // Decay the average: 4 x 1920 stays OK (10560), the 5th drops to 8400 -> DEGRADED.
      for (int i = 0; i < 4; i++) strobe(18'd1920, 1'b0);
      check("decay4_avg", 32'(avg_out), 32'd10560);
      check("decay4_state", 32'(link_state), 32'd1);
      strobe(18'd1920, 1'b0);
      check("decay5_avg", 32'(avg_out), 32'd8400);
      check("decay5_state", 32'(link_state), 32'd2);

      // Three consecutive zeros declare loss; a nonzero sample recovers to DEGRADED.
      strobe(18'd0, 1'b0);
      check("z1_avg", 32'(avg_out), 32'd6000);
      check("z1_state", 32'(link_state), 32'd2);
      strobe(18'd0, 1'b0);
      check("z2_state", 32'(link_state), 32'd2);
      check("z2_alarm", 32'(alarm), 32'd0);
      strobe(18'd0, 1'b0);
      check("z3_avg", 32'(avg_out), 32'd1200);
      check("z3_state", 32'(link_state), 32'd3);
      check("z3_alarm", 32'(alarm), 32'd1);
      strobe(18'd1920, 1'b0);
      check("rec_avg", 32'(avg_out), 32'd1200);
      check("rec_state", 32'(link_state), 32'd2);
      check("rec_alarm", 32'(alarm), 32'd0);
      check("rec_min", 32'(min_out), 32'd0);
      check("rec_max", 32'(max_out), 32'd19200);

      // Standalone clear, then buffer wrap 8 x 1920 -> 8 x 3840.
      pulse_clr();
      check("clr_min", 32'(min_out), 32'h3FFFF);
      check("clr_max", 32'(max_out), 32'd0);
      check("clr_state", 32'(link_state), 32'd0);
      check("clr_alarm", 32'(alarm), 32'd0);
      for (int i = 0; i < 8; i++) strobe(18'd1920, 1'b0);
      check("wrapA_avg", 32'(avg_out), 32'd1920);
      check("wrapA_avgv", 32'(avg_valid), 32'd1);
      check("wrapA_state", 32'(link_state), 32'd2);
      for (int i = 0; i < 8; i++) begin
         strobe(18'd3840, 1'b0);
         check($sformatf("wrapB_avg_%0d", i), 32'(avg_out), 32'(1920 + 240 * (i + 1)));
         check($sformatf("wrapB_avgv_%0d", i), 32'(avg_valid), 32'd1);
      end
      check("wrap_minmax", {min_out[15:0], max_out[15:0]}, {16'd1920, 16'd3840});
      check("wrap_state", 32'(link_state), 32'd2);

      // Clear coincident with a strobe: the sample becomes sample 1 of a fresh run.
      pulse_clr();
      strobe(18'd3840, 1'b0);
      strobe(18'd1920, 1'b0);
      strobe(18'd57600, 1'b0);
      check("mm_min", 32'(min_out), 32'd1920);
      check("mm_max", 32'(max_out), 32'd57600);
      strobe(18'd5760, 1'b1);
      check("clrdv_min", 32'(min_out), 32'd5760);
      check("clrdv_max", 32'(max_out), 32'd5760);
      check("clrdv_state", 32'(link_state), 32'd0);
      check("clrdv_avgv", 32'(avg_valid), 32'd0);
      for (int i = 0; i < 6; i++) strobe(18'd5760, 1'b0);
      check("clrdv7_avgv", 32'(avg_valid), 32'd0);
      strobe(18'd5760, 1'b0);
      check("clrdv8_avgv", 32'(avg_valid), 32'd1);
      check("clrdv8_avg", 32'(avg_out), 32'd5760);
      check("clrdv8_state", 32'(link_state), 32'd2);

      // Asynchronous reset mid-fill, then a full refill is needed.
      pulse_clr();
      for (int i = 0; i < 5; i++) strobe(18'd19200, 1'b0);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 7; i++) strobe(18'd19200, 1'b0);
      check("refill7_avgv", 32'(avg_valid), 32'd0);
      strobe(18'd19200, 1'b0);
      check("refill8_avgv", 32'(avg_valid), 32'd1);
      check("refill8_avg", 32'(avg_out), 32'd19200);
      check("refill8_state", 32'(link_state), 32'd1);

      // Interrupted zero run does not declare loss; avg exactly at LOW_THR stays OK.
      strobe(18'd0, 1'b0);
      strobe(18'd0, 1'b0);
      strobe(18'd19200, 1'b0);
      strobe(18'd0, 1'b0);
      strobe(18'd0, 1'b0);
      check("low_edge_avg", 32'(avg_out), 32'd9600);
      check("low_edge_state", 32'(link_state), 32'd1);
      strobe(18'd0, 1'b0);
      check("z3b_state", 32'(link_state), 32'd3);
      check("z3b_avg", 32'(avg_out), 32'd7200);
      strobe(18'd0, 1'b0);
      check("lost_hold", 32'(link_state), 32'd3);
      pulse_clr();
      check("lost_clr_state", 32'(link_state), 32'd0);
      check("lost_clr_alarm", 32'(alarm), 32'd0);

`ifdef RATE_MON_WDOG_EN
      // Counter is 0 after the clear edge; a strobe while at the limit suppresses the trip.
      repeat (int'(TbWdogMax)) @(negedge clk);
      check("wd_at_max", 32'(wdog_err), 32'd0);
      strobe(18'd19200, 1'b0);
      check("wd_dv_wins", 32'(wdog_err), 32'd0);
      repeat (int'(TbWdogMax)) @(negedge clk);
      check("wd_pre_trip", 32'(wdog_err), 32'd0);
      @(negedge clk);
      check("wd_trip_err", 32'(wdog_err), 32'd1);
      check("wd_trip_state", 32'(link_state), 32'd3);
      check("wd_trip_alarm", 32'(alarm), 32'd1);
      repeat (4) @(negedge clk);
      check("wd_sticky", 32'(wdog_err), 32'd1);
      pulse_clr();
      check("wd_clr_err", 32'(wdog_err), 32'd0);
      check("wd_clr_state", 32'(link_state), 32'd0);
`else
      repeat (50) @(negedge clk);
      check("wd_tied", 32'(wdog_err), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
